// File: rtl/prog_stream_gen.sv
// rtl/prog_stream_gen.sv - loadable program buffer streamed to the core with loops and NOP drain
module prog_stream_gen #(
  parameter int                   DEPTH      = 16,
  parameter int                   AW         = 4,
  parameter int                   WORD_SIZE  = 32,
  parameter logic [WORD_SIZE-1:0] NOP        = 32'h00000013,
  parameter int                   DRAIN_NOPS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_en,
  input  logic [AW-1:0]        load_addr,
  input  logic [WORD_SIZE-1:0] load_data,
  input  logic [AW:0]          prog_len,
  input  logic [7:0]           loop_cnt,
  input  logic                 start,
  input  logic                 instr_ready,
  output logic [WORD_SIZE-1:0] instr,
  output logic                 instr_valid,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          issue_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [AW:0]   DEPTH_W    = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PC_ONE     = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [7:0]    DRAIN_INIT = 8'(DRAIN_NOPS);

  logic [WORD_SIZE-1:0] mem [DEPTH];

  state_t               state_q, state_d;
  logic [AW-1:0]        pc_q, pc_d;
  logic [AW-1:0]        last_pc_q, last_pc_d;
  logic [7:0]           loops_q, loops_d;
  logic [7:0]           drain_q, drain_d;
  logic [WORD_SIZE-1:0] instr_q, instr_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 busy_int;
  logic                 start_ok;
  logic                 xfer;

  assign busy_int    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign busy        = busy_int;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign done        = done_q;
  assign issue_cnt   = cnt_q;

  // A start that coincides with a buffer write is dropped so the write can never race the first fetch.
  assign start_ok = start && !load_en && (prog_len != '0) && (prog_len <= DEPTH_W);
  assign xfer     = valid_q && instr_ready;

  // Program buffer: written only while idle, never cleared by reset.
  always_ff @(posedge clk) begin
    if (load_en && !busy_int) begin
      mem[load_addr] <= load_data;
    end
  end

  // State and registered output slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      last_pc_q <= '0;
      loops_q   <= '0;
      drain_q   <= '0;
      instr_q   <= NOP;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      last_pc_q <= last_pc_d;
      loops_q   <= loops_d;
      drain_q   <= drain_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state, next output slot and bookkeeping counters.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    last_pc_d = last_pc_q;
    loops_d   = loops_q;
    drain_d   = drain_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    done_d    = done_q;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        instr_d = NOP;
        valid_d = 1'b0;
        if (start_ok) begin
          state_d   = S_ISSUE;
          pc_d      = '0;
          // prog_len == DEPTH has zero low bits, so the wrap yields DEPTH-1.
          last_pc_d = prog_len[AW-1:0] - PC_ONE;
          loops_d   = (loop_cnt == 8'd0) ? 8'd1 : loop_cnt;
          cnt_d     = '0;
          done_d    = 1'b0;
        end
      end

      S_ISSUE: begin
        if (!valid_q) begin
          // First slot after an accepted start.
          instr_d = mem[pc_q];
          valid_d = 1'b1;
        end else if (xfer) begin
          if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
          if (pc_q != last_pc_q) begin
            pc_d    = pc_q + PC_ONE;
            instr_d = mem[pc_q + PC_ONE];
          end else if (loops_q > 8'd1) begin
            loops_d = loops_q - 8'd1;
            pc_d    = '0;
            instr_d = mem[0];
          end else if (DRAIN_NOPS == 0) begin
            state_d = S_DONE;
            instr_d = NOP;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_DRAIN;
            instr_d = NOP;
            valid_d = 1'b1;
            drain_d = DRAIN_INIT;
          end
        end
      end

      S_DRAIN: begin
        if (xfer) begin
          drain_d = drain_q - 8'd1;
          if (drain_q == 8'd1) begin
            state_d = S_DONE;
            instr_d = NOP;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        instr_d = NOP;
        valid_d = 1'b0;
      end
    endcase
  end

endmodule
